// File: rtl/dft_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dft_chk_pkg
//  Description : Shared types and default sizing for the pattern/response
//                checker (FSM state encoding, default widths and counts).
//  Revision    : 1.0 - initial release
// ============================================================================
package dft_chk_pkg;

   // Default sizing for the checker
   localparam int DEF_OUT_W   = 3;
   localparam int DEF_NUM_PAT = 5;
   localparam int DEF_CNT_W   = 8;

   // Session state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chk_state_t;

endpackage : dft_chk_pkg
`default_nettype wire

// File: rtl/pat_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pat_resp_checker
//  Description : Joins an observed-response stream with a gold-response
//                stream, compares each pair and accumulates session results
//                (fail flag, saturating fail count, OR of mismatch bits and
//                the index of the first failing pattern).
//  Revision    : 1.0 - initial release
// ============================================================================
module pat_resp_checker
   import dft_chk_pkg::*;
#(
   parameter int OUT_W   = DEF_OUT_W,
   parameter int NUM_PAT = DEF_NUM_PAT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             obs_valid,
   input  logic [OUT_W-1:0] obs_data,
   output logic             obs_ready,
   input  logic             exp_valid,
   input  logic [OUT_W-1:0] exp_data,
   output logic             exp_ready,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [OUT_W-1:0] fail_bits,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [CNT_W-1:0] pat_idx
);

   // Index of the final pattern in a session and the saturation ceiling
   localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_PAT - 1);
   localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

   chk_state_t       r_state;
   logic [CNT_W-1:0] r_pat_idx;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [CNT_W-1:0] r_first_fail_idx;
   logic [OUT_W-1:0] r_fail_bits;
   logic             r_fail;

   logic             w_run;
   logic             w_take;
   logic             w_enter;
   logic [OUT_W-1:0] w_mis;
   logic             w_pat_fail;

   // Join handshake: each side is only accepted when its partner is present,
   // so neither stream can ever be consumed on its own.
   assign w_run      = (r_state == ST_RUN);
   assign obs_ready  = w_run & exp_valid;
   assign exp_ready  = w_run & obs_valid;
   assign w_take     = w_run & obs_valid & exp_valid;
   assign w_enter    = start & ~w_run;
   assign w_mis      = obs_data ^ exp_data;
   assign w_pat_fail = |w_mis;

   // Session FSM and result accumulation; start wins over a pending pair
   // outside RUN because the readies are low there.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_pat_idx        <= '0;
         r_fail_cnt       <= '0;
         r_first_fail_idx <= '0;
         r_fail_bits      <= '0;
         r_fail           <= 1'b0;
      end else if (w_enter) begin
         r_state          <= ST_RUN;
         r_pat_idx        <= '0;
         r_fail_cnt       <= '0;
         r_first_fail_idx <= '0;
         r_fail_bits      <= '0;
         r_fail           <= 1'b0;
      end else if (w_take) begin
         r_pat_idx <= r_pat_idx + CNT_W'(1);
         if (w_pat_fail) begin
            r_fail      <= 1'b1;
            r_fail_bits <= r_fail_bits | w_mis;
            if (r_fail_cnt != c_cnt_max) begin
               r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
            if (!r_fail) begin
               r_first_fail_idx <= r_pat_idx;
            end
         end
         if (r_pat_idx == c_last_idx) begin
            r_state <= ST_DONE;
         end
      end else if ((r_state != ST_IDLE) && (r_state != ST_RUN) &&
                   (r_state != ST_DONE)) begin
         r_state <= ST_IDLE;
      end
   end

   // Status flags are plain decodes of the registered state
   assign busy           = (r_state == ST_RUN);
   assign done           = (r_state == ST_DONE);
   assign fail           = r_fail;
   assign fail_cnt       = r_fail_cnt;
   assign fail_bits      = r_fail_bits;
   assign first_fail_idx = r_first_fail_idx;
   assign pat_idx        = r_pat_idx;

endmodule : pat_resp_checker
`default_nettype wire
